// File: rtl/sico_arb_pkg.sv
// Shared types and header helpers for the SiCo channel arbiter and related muxes.
package sico_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } arb_state_e;

  // Header marker sits in the top bit of the beat.
  function automatic int unsigned hdr_mark_pos(input int unsigned data_w);
    return data_w - 1;
  endfunction

  // Header is built one bit at a time so any DATA_W can use it without slicing.
  function automatic logic header_bit(input int unsigned data_w,
                                      input logic [3:0]  port,
                                      input int unsigned b);
    logic [1:0] sel;
    sel = b[1:0];
    if (b == hdr_mark_pos(data_w)) return 1'b1;
    if (b < 4) return port[sel];
    return 1'b0;
  endfunction

endpackage

// File: rtl/sico_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping.
module sico_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  int unsigned cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = (32'(ptr) + i) % NUM_PORTS;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sico_chan_arbiter.sv
// Packet-level round-robin arbiter sharing one SiCo channel; each packet is
// prefixed with a header beat carrying the source port index.
module sico_chan_arbiter
  import sico_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_PORTS-1:0]          in_valid_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data_i,
  input  logic [NUM_PORTS-1:0]          in_last_i,
  output logic [NUM_PORTS-1:0]          in_ready_o,
  output logic                          out_valid_o,
  output logic [DATA_W-1:0]             out_data_o,
  output logic                          out_last_o,
  input  logic                          out_ready_i,
  output logic                          busy_o,
  output logic [15:0]                   pkt_count_o
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_e          state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    grant;
  logic [NUM_PORTS-1:0] pick_gnt;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                slot_free;
  logic                sel_valid;
  logic                sel_last;
  logic [DATA_W-1:0]   sel_data;
  logic                beat_acc;
  logic [DATA_W-1:0]   hdr_word;

  sico_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req (in_valid_i),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign slot_free = !out_valid_o || out_ready_i;
  assign busy_o    = (state != IDLE);
  assign beat_acc  = (state == PAYLOAD) && sel_valid && slot_free;

  always_comb begin
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    sel_data   = '0;
    in_ready_o = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (IDX_W'(p) == grant) begin
        sel_valid     = in_valid_i[p];
        sel_last      = in_last_i[p];
        sel_data      = in_data_i[p*DATA_W +: DATA_W];
        in_ready_o[p] = (state == PAYLOAD) && slot_free;
      end
    end
  end

  always_comb begin
    hdr_word = '0;
    for (int unsigned b = 0; b < DATA_W; b++)
      hdr_word[b] = header_bit(DATA_W, 4'(pick_idx), b);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
      pkt_count_o <= '0;
    end else begin
      // Drain first; a refill below in the same cycle overrides it.
      if (out_valid_o && out_ready_i)
        out_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any && slot_free) begin
            grant       <= pick_idx;
            out_valid_o <= 1'b1;
            out_data_o  <= hdr_word;
            out_last_o  <= 1'b0;
            state       <= HEADER;
          end
        end
        HEADER: begin
          if (out_valid_o && out_ready_i)
            state <= PAYLOAD;
        end
        PAYLOAD: begin
          if (beat_acc) begin
            out_valid_o <= 1'b1;
            out_data_o  <= sel_data;
            out_last_o  <= sel_last;
            if (sel_last) begin
              pkt_count_o <= pkt_count_o + 16'd1;
              rr_ptr      <= (grant == IDX_W'(NUM_PORTS - 1)) ? '0 : grant + IDX_W'(1);
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
